// File: rtl/tpm_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tpm_cmd_assembler
//  Description : Pops a TPM command stream from an upstream FIFO with
//                one-cycle read latency. It parses the 10-byte header
//                (tag, commandSize and commandCode, all big-endian) and then
//                hands the body bytes downstream through a one-entry holding
//                register with valid/ready flow control. Frames with an
//                illegal commandSize are drained from the FIFO and dropped.
//  Ports       : clk, rst            clock, asynchronous active-high reset
//                fifo_dout/empty     upstream FIFO read data / empty flag
//                fifo_rd_en          upstream FIFO pop strobe
//                hdr_tag/size/code   captured header fields
//                hdr_valid           pulse when the header fields update
//                out_data/valid/last body byte stream to downstream
//                out_ready           downstream accepts the body byte
//                frame_done          pulse when a frame is fully delivered
//                err_size            pulse when commandSize is illegal
//                busy                high in any state other than IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module tpm_cmd_assembler #(
   parameter int unsigned MAX_SIZE = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  fifo_dout,
   input  logic        fifo_empty,
   output logic        fifo_rd_en,
   output logic [15:0] hdr_tag,
   output logic [31:0] hdr_size,
   output logic [31:0] hdr_code,
   output logic        hdr_valid,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        frame_done,
   output logic        err_size,
   output logic        busy
);

   localparam logic [31:0] c_max_size = 32'(MAX_SIZE);
   localparam logic [31:0] c_hdr_len  = 32'd10;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HDR     = 2'd1,
      S_BODY    = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        inflight_q, inflight_d;   // pop issued last cycle, data on fifo_dout now
   logic [3:0]  hcnt_q, hcnt_d;           // header bytes received so far
   logic [15:0] tag_sh_q, tag_sh_d;
   logic [31:0] size_sh_q, size_sh_d;
   logic [31:0] code_sh_q, code_sh_d;
   logic [15:0] body_cnt_q, body_cnt_d;   // body bytes still to be received
   logic [15:0] hdr_tag_q, hdr_tag_d;
   logic [31:0] hdr_size_q, hdr_size_d;
   logic [31:0] hdr_code_q, hdr_code_d;
   logic        hdr_valid_q, hdr_valid_d;
   logic        frame_done_q, frame_done_d;
   logic        err_size_q, err_size_d;
   logic        hold_full_q, hold_full_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_last_q, out_last_d;
   logic        rd_en;
   logic [31:0] size_full;

   // Complete commandSize as it stands once byte 5 lands.
   assign size_full = {size_sh_q[23:0], fifo_dout};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         inflight_q   <= 1'b0;
         hcnt_q       <= 4'd0;
         tag_sh_q     <= 16'd0;
         size_sh_q    <= 32'd0;
         code_sh_q    <= 32'd0;
         body_cnt_q   <= 16'd0;
         hdr_tag_q    <= 16'd0;
         hdr_size_q   <= 32'd0;
         hdr_code_q   <= 32'd0;
         hdr_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         err_size_q   <= 1'b0;
         hold_full_q  <= 1'b0;
         out_data_q   <= 8'd0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         inflight_q   <= inflight_d;
         hcnt_q       <= hcnt_d;
         tag_sh_q     <= tag_sh_d;
         size_sh_q    <= size_sh_d;
         code_sh_q    <= code_sh_d;
         body_cnt_q   <= body_cnt_d;
         hdr_tag_q    <= hdr_tag_d;
         hdr_size_q   <= hdr_size_d;
         hdr_code_q   <= hdr_code_d;
         hdr_valid_q  <= hdr_valid_d;
         frame_done_q <= frame_done_d;
         err_size_q   <= err_size_d;
         hold_full_q  <= hold_full_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hcnt_d       = hcnt_q;
      tag_sh_d     = tag_sh_q;
      size_sh_d    = size_sh_q;
      code_sh_d    = code_sh_q;
      body_cnt_d   = body_cnt_q;
      hdr_tag_d    = hdr_tag_q;
      hdr_size_d   = hdr_size_q;
      hdr_code_d   = hdr_code_q;
      hdr_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      err_size_d   = 1'b0;
      hold_full_d  = hold_full_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      rd_en        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               rd_en   = 1'b1;
               hcnt_d  = 4'd0;
               state_d = S_HDR;
            end
         end

         S_HDR: begin
            if (inflight_q) begin
               if (hcnt_q < 4'd2)
                  tag_sh_d = {tag_sh_q[7:0], fifo_dout};
               else if (hcnt_q < 4'd6)
                  size_sh_d = size_full;
               else
                  code_sh_d = {code_sh_q[23:0], fifo_dout};
               hcnt_d = hcnt_q + 4'd1;

               if (hcnt_q == 4'd5) begin
                  // Full 32-bit compare: anything >= 2^16 also exceeds MAX_SIZE.
                  if ((size_full < c_hdr_len) || (size_full > c_max_size)) begin
                     err_size_d = 1'b1;
                     state_d    = S_DISCARD;
                  end
               end

               if (hcnt_q == 4'd9) begin
                  hdr_valid_d = 1'b1;
                  hdr_tag_d   = tag_sh_q;
                  hdr_size_d  = size_sh_q;
                  hdr_code_d  = {code_sh_q[23:0], fifo_dout};
                  if (size_sh_q == c_hdr_len) begin
                     frame_done_d = 1'b1;
                     state_d      = S_IDLE;
                  end else begin
                     body_cnt_d = size_sh_q[15:0] - 16'd10;
                     state_d    = S_BODY;
                  end
               end
            end else if (!fifo_empty) begin
               rd_en = 1'b1;
            end
         end

         S_BODY: begin
            if (hold_full_q && out_ready) begin
               hold_full_d = 1'b0;
               out_last_d  = 1'b0;
               if (out_last_q) begin
                  frame_done_d = 1'b1;
                  state_d      = S_IDLE;
               end
            end
            if (inflight_q) begin
               hold_full_d = 1'b1;
               out_data_d  = fifo_dout;
               out_last_d  = (body_cnt_q == 16'd1);
               body_cnt_d  = body_cnt_q - 16'd1;
            end else if (!fifo_empty && (body_cnt_q != 16'd0) &&
                         (!hold_full_q || out_ready)) begin
               // A byte being accepted this cycle frees the holding register
               // before the new byte lands, which keeps one byte per two clocks.
               rd_en = 1'b1;
            end
         end

         S_DISCARD: begin
            if (!inflight_q) begin
               if (!fifo_empty)
                  rd_en = 1'b1;
               else
                  state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      inflight_d = rd_en;
   end

   assign fifo_rd_en = rd_en & ~rst;
   assign hdr_tag    = hdr_tag_q;
   assign hdr_size   = hdr_size_q;
   assign hdr_code   = hdr_code_q;
   assign hdr_valid  = hdr_valid_q;
   assign out_data   = out_data_q;
   assign out_valid  = hold_full_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;
   assign err_size   = err_size_q;
   assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/tpm_cmd_assembler.md
TPM_CMD_ASSEMBLER -- requirements
Module: tpm_cmd_assembler

Interface
REQ-001 Parameter: MAX_SIZE, default 4096, largest legal TPM command size in bytes (valid range 10..65535).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 fifo_dout  in  8  byte from the upstream FIFO read port.
REQ-005 fifo_empty  in  1  upstream FIFO empty flag.
REQ-006 fifo_rd_en  out  1  upstream FIFO pop strobe.
REQ-007 hdr_tag  out  16  captured TPM tag (bytes 0-1, big-endian).
REQ-008 hdr_size  out  32  captured commandSize (bytes 2-5, big-endian).
REQ-009 hdr_code  out  32  captured commandCode (bytes 6-9, big-endian).
REQ-010 hdr_valid  out  1  one-cycle pulse: valid header captured.
REQ-011 out_data  out  8  body byte.
REQ-012 out_valid  out  1  body byte available.
REQ-013 out_ready  in  1  downstream accepts body byte.
REQ-014 out_last  out  1  marks final body byte; qualified by out_valid.
REQ-015 frame_done  out  1  one-cycle pulse: frame fully delivered.
REQ-016 err_size  out  1  one-cycle pulse: illegal commandSize.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FIFO read latency: fifo_dout is valid exactly one cycle after fifo_rd_en is high.
REQ-019 fifo_rd_en is asserted only when fifo_empty=0, no read is in flight, and the body holding register is empty; it is never asserted while empty=1.
REQ-020 Peak throughput: one byte per two clocks.
REQ-021 States: IDLE, HDR, BODY, DISCARD.
REQ-022 IDLE: on the first pop, go to HDR; the header byte counter resets to 0.
REQ-023 HDR: each returned byte shifts into tag/size/code by index 0..9; the hdr_* outputs update only on the pulse in REQ-026.
REQ-024 After byte 5: if size<10 or size>MAX_SIZE, pulse err_size in the next cycle and go to DISCARD; no hdr_valid or body output is produced.
REQ-025 DISCARD: pop while fifo_empty=0. Return to IDLE on the first cycle with fifo_empty=1 and no read in flight.
REQ-026 After byte 9: pulse hdr_valid together with the hdr_* update. If size==10, pulse frame_done in the same cycle and go to IDLE. Otherwise load the body counter with size-10 and go to BODY.
REQ-027 BODY: each returned byte enters the holding register, and out_valid=1 while the register is full. out_data and out_last are held stable until out_valid & out_ready.
REQ-028 out_last=1 on the byte for which the body counter equals 1.
REQ-029 On acceptance of the last byte: pulse frame_done in the next cycle, go to IDLE, and issue no further pops for this frame.
REQ-030 Backpressure: out_ready=0 stalls pops. The FIFO is never over-read past size bytes per frame.
REQ-031 fifo_empty=1 mid-frame: wait indefinitely in HDR or BODY with no timeout, no data loss, and no spurious outputs.
REQ-032 Size compare uses the full 32-bit value; sizes >=2^16 are errors regardless of MAX_SIZE.
REQ-033 err_size, hdr_valid and frame_done are mutually exclusive within a cycle, except hdr_valid with frame_done when size==10.

Reset
REQ-034 rst=1: state IDLE; fifo_rd_en, out_valid, out_last, hdr_valid, frame_done, err_size, busy all 0; hdr_tag, hdr_size, hdr_code, out_data all 0; counters 0; in-flight flag cleared.
REQ-035 Reset mid-frame abandons the frame. A byte returning from a pop issued before reset is ignored, and no output pulse follows reset release.

Verification
REQ-036 FIFO holds 80 01 00 00 00 0C 00 00 01 44 AA BB, out_ready=1 -> hdr_valid with tag=8001, size=12, code=0x00000144; out bytes AA then BB with out_last on BB; one frame_done.
REQ-037 FIFO holds 80 01 00 00 00 0A 00 00 01 7B -> hdr_valid and frame_done in the same cycle; out_valid never high.
REQ-038 size=0x00000005 followed by 20 more bytes -> err_size once; all bytes popped; returns to IDLE; no hdr_valid and no out_valid.
REQ-039 Valid 14-byte frame with out_ready toggling 0/1 every 3 cycles -> exactly 4 body bytes in order, data stable while stalled, and total pops = 14.
REQ-040 Upstream writes bytes with empty=1 gaps of 5 cycles between bytes -> identical output to REQ-036; fifo_rd_en never high while empty=1.
REQ-041 rst pulsed after byte 7 of a frame, then a new 12-byte frame is presented -> the second frame is parsed correctly with no leftover or stray pulses.
